// File: rtl/uart_rx_frame_pkg.sv
// Shared UART receive constants, FSM state encoding and the delivered-frame payload.
package uart_rx_frame_pkg;

  localparam int unsigned UART_BIT_CYCLES  = 5210;
  localparam int unsigned UART_HALF_CYCLES = 2605;
  localparam int unsigned UART_DATA_BITS   = 8;
  localparam int unsigned BIT_CNT_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      parity_err;
    logic                      frame_err;
  } rx_result_t;

  // Even parity: the received parity bit must equal the XOR of the data bits.
  function automatic logic even_parity_err(input logic [UART_DATA_BITS-1:0] data,
                                           input logic                      par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer: counts from 0 after each restart and ticks at the half or full bit point.
module uart_rx_bit_timer
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = UART_BIT_CYCLES,
  parameter int unsigned HALF_CYCLES = UART_HALF_CYCLES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic restart,
  input  logic half_sel,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);

  logic [CNT_W-1:0] count;

  // Counter clears on a state change and after every tick, so each bit period starts at 0.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = half_sel ? (count == CNT_W'(HALF_CYCLES - 1))
                         : (count == CNT_W'(BIT_CYCLES - 1));

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit; delivers byte plus status.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = UART_BIT_CYCLES,
  parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic [2:0] rx_state
);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      rx_s;
  logic                      rx_d;

  rx_state_e                 state;
  rx_state_e                 state_next;
  logic                      restart_c;
  logic                      half_sel_c;
  logic                      tick;

  logic [UART_DATA_BITS-1:0] shreg;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic                      par_bit;
  logic                      stop_bit;
  rx_result_t                result;

  // Synchronizer resets to idle-high so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_d   <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_rx_bit_timer #(
    .BIT_CYCLES  (BIT_CYCLES),
    .HALF_CYCLES (HALF_CYCLES)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .restart  (restart_c),
    .half_sel (half_sel_c),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    half_sel_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rx_d && !rx_s) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        half_sel_c = 1'b1;
        if (tick) begin
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && (bit_cnt == BIT_CNT_W'(UART_DATA_BITS - 1))) begin
          state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    restart_c = (state_next != state);
  end

  // Sampling datapath: every sample is taken from rx_s on the timer tick.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
    end else begin
      if (state == ST_START) begin
        bit_cnt <= '0;
      end
      if ((state == ST_DATA) && tick) begin
        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
      if ((state == ST_PARITY) && tick) begin
        par_bit <= rx_s;
      end
      if ((state == ST_STOP) && tick) begin
        stop_bit <= rx_s;
      end
    end
  end

  // Delivery: frames with errors are still delivered; a valid pulse beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      result   <= '0;
      rx_valid <= 1'b0;
      rx_ready <= 1'b0;
    end else begin
      rx_valid <= (state == ST_DONE);
      if (state == ST_DONE) begin
        result <= '{data:       shreg,
                    parity_err: even_parity_err(shreg, par_bit),
                    frame_err:  ~stop_bit};
        rx_ready <= 1'b1;
      end else if (rx_clear && !rx_valid) begin
        rx_ready <= 1'b0;
      end
    end
  end

  assign rx_data    = result.data;
  assign parity_err = result.parity_err;
  assign frame_err  = result.frame_err;
  assign rx_state   = state;

endmodule
